// File: rtl/m_unit_iter_pkg.sv
// Shared constants, FSM encoding and func3 decode helpers for the iterative M unit.
package m_unit_pkg;

  localparam int unsigned F3_W = 3;
  localparam int unsigned RD_W = 5;

  localparam logic [F3_W-1:0] F3_MUL    = 3'b000;
  localparam logic [F3_W-1:0] F3_MULH   = 3'b001;
  localparam logic [F3_W-1:0] F3_MULHSU = 3'b010;
  localparam logic [F3_W-1:0] F3_MULHU  = 3'b011;
  localparam logic [F3_W-1:0] F3_DIV    = 3'b100;
  localparam logic [F3_W-1:0] F3_DIVU   = 3'b101;
  localparam logic [F3_W-1:0] F3_REM    = 3'b110;
  localparam logic [F3_W-1:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_CALC = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Divide/remainder ops all live in the upper half of the func3 space.
  function automatic logic is_div(input logic [F3_W-1:0] f3);
    return f3[2];
  endfunction

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
  function automatic logic is_signed_op1(input logic [F3_W-1:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM.
  function automatic logic is_signed_op2(input logic [F3_W-1:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/m_unit_iter_if.sv
// Execute-stage request/response bundle of the iterative M unit.
interface m_unit_iter_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      func3;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [4:0]      rd_in;
  logic            busy;
  logic            stall_req;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;
  logic            wb_reg_file;

  modport master (
    output start, flush, func3, op1, op2, rd_in,
    input  busy, stall_req, done, result, rd_out, wb_reg_file
  );

  modport slave (
    input  start, flush, func3, op1, op2, rd_in,
    output busy, stall_req, done, result, rd_out, wb_reg_file
  );
endinterface

// File: rtl/m_unit_iter_step.sv
// One combinational radix-2 step: shift-add multiply or restoring divide.
module m_unit_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic              div_i,
  input  logic [XLEN-1:0]   b_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN:0]     rem_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic [XLEN:0]     rem_o
);

  logic [XLEN-1:0] addend;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // Multiply: add multiplicand on lsb, shift right. Divide: shift in next dividend bit, trial subtract.
  always_comb begin
    addend  = acc_i[0] ? b_i : '0;
    sum     = {1'b0, acc_i[2*XLEN-1:XLEN]} + {1'b0, addend};
    shifted = {rem_i[XLEN-1:0], acc_i[XLEN-1]};
    diff    = shifted - {1'b0, b_i};
    acc_o   = {sum, acc_i[XLEN-1:1]};
    rem_o   = rem_i;
    if (div_i) begin
      rem_o = diff[XLEN] ? shifted : diff;
      acc_o = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-2:0], ~diff[XLEN]};
    end
  end

endmodule

// File: rtl/m_unit_iter.sv
// Iterative RV32M/RV64M multiply/divide unit retiring BPC bits per cycle.
module m_unit_iter
  import m_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned BPC  = 1
) (
  input  logic          clk,
  input  logic          rst,
  m_unit_iter_if.slave  bus
);

  localparam int unsigned N_ITER = XLEN / BPC;
  localparam int unsigned CNT_W  = $clog2(N_ITER + 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e              state_q, state_d;
  logic [F3_W-1:0]     f3_q, f3_d;
  logic [RD_W-1:0]     rd_q, rd_d;
  logic [XLEN-1:0]     op1_q, op1_d;
  logic [XLEN-1:0]     op2_q, op2_d;
  logic                sign1_q, sign1_d;
  logic                sign2_q, sign2_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN:0]       rem_q, rem_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [RD_W-1:0]     rd_out_q, rd_out_d;
  logic                done_q, done_d;

  logic                div_op;
  logic [2*XLEN-1:0]   acc_nx;
  logic [XLEN:0]       rem_nx;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quo_fix;
  logic [XLEN-1:0]     rem_fix;
  logic                s1, s2;
  logic [XLEN-1:0]     mag1, mag2;

  assign div_op = is_div(f3_q);

  // Chain BPC radix-2 steps per cycle.
  for (genvar g = 0; g < int'(BPC); g++) begin : g_step
    logic [2*XLEN-1:0] acc_in, acc_out;
    logic [XLEN:0]     rem_in, rem_out;
    if (g == 0) begin : g_first
      assign acc_in = acc_q;
      assign rem_in = rem_q;
    end else begin : g_next
      assign acc_in = g_step[g-1].acc_out;
      assign rem_in = g_step[g-1].rem_out;
    end
    m_unit_step #(.XLEN(XLEN)) u_step (
      .div_i (div_op),
      .b_i   (b_q),
      .acc_i (acc_in),
      .rem_i (rem_in),
      .acc_o (acc_out),
      .rem_o (rem_out)
    );
  end

  assign acc_nx = g_step[BPC-1].acc_out;
  assign rem_nx = g_step[BPC-1].rem_out;

  // Operand magnitudes and final sign fix-up of the last iteration's output.
  always_comb begin
    s1       = is_signed_op1(f3_q) & op1_q[XLEN-1];
    s2       = is_signed_op2(f3_q) & op2_q[XLEN-1];
    mag1     = s1 ? -op1_q : op1_q;
    mag2     = s2 ? -op2_q : op2_q;
    prod_fix = (sign1_q ^ sign2_q) ? -acc_nx : acc_nx;
    quo_fix  = (sign1_q ^ sign2_q) ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
    rem_fix  = sign1_q ? -rem_nx[XLEN-1:0] : rem_nx[XLEN-1:0];
  end

  // Next-state and datapath update; flush overrides everything outside IDLE.
  always_comb begin
    state_d  = state_q;
    f3_d     = f3_q;
    rd_d     = rd_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    sign1_d  = sign1_q;
    sign2_d  = sign2_q;
    b_d      = b_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.flush) begin
          state_d = ST_PREP;
          f3_d    = bus.func3;
          rd_d    = bus.rd_in;
          op1_d   = bus.op1;
          op2_d   = bus.op2;
        end
      end
      ST_PREP: begin
        if (div_op && (op2_q == '0)) begin
          state_d  = ST_DONE;
          done_d   = 1'b1;
          rd_out_d = rd_q;
          result_d = f3_q[1] ? op1_q : '1;
        end else if (((f3_q == F3_DIV) || (f3_q == F3_REM)) &&
                     (op1_q == MOST_NEG) && (op2_q == '1)) begin
          state_d  = ST_DONE;
          done_d   = 1'b1;
          rd_out_d = rd_q;
          result_d = f3_q[1] ? '0 : op1_q;
        end else begin
          state_d = ST_CALC;
          sign1_d = s1;
          sign2_d = s2;
          rem_d   = '0;
          cnt_d   = CNT_W'(N_ITER);
          if (div_op) begin
            b_d   = mag2;
            acc_d = {{XLEN{1'b0}}, mag1};
          end else begin
            b_d   = mag1;
            acc_d = {{XLEN{1'b0}}, mag2};
          end
        end
      end
      ST_CALC: begin
        acc_d = acc_nx;
        rem_d = rem_nx;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = ST_DONE;
          done_d   = 1'b1;
          rd_out_d = rd_q;
          if (div_op) begin
            result_d = f3_q[1] ? rem_fix : quo_fix;
          end else if (f3_q == F3_MUL) begin
            result_d = prod_fix[XLEN-1:0];
          end else begin
            result_d = prod_fix[2*XLEN-1:XLEN];
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (bus.flush && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      done_d   = 1'b0;
      result_d = result_q;
      rd_out_d = rd_out_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      f3_q     <= '0;
      rd_q     <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      b_q      <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      rd_out_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      rd_q     <= rd_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      sign1_q  <= sign1_d;
      sign2_q  <= sign2_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.stall_req   = (bus.start && !bus.flush && (state_q == ST_IDLE)) ||
                           (state_q == ST_PREP) || (state_q == ST_CALC);
  assign bus.done        = done_q;
  assign bus.wb_reg_file = done_q;
  assign bus.result      = result_q;
  assign bus.rd_out      = rd_out_q;

endmodule

// File: doc/m_unit_iter.md
Name: m_unit_iter

Overview:
Parametrised iterative RV32M/RV64M multiply/divide unit for the execute stage. It replaces single-cycle M-unit arithmetic with a shift-add / restoring-division engine that retires BPC bits per cycle. While an operation is in flight it stalls the front of the pipeline. It takes already-forwarded operands, so forwarding stays in the execute stage, and returns a result plus writeback tag to the EX/MEM register.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
BPC, 1, bits retired per iteration; legal values 1, 2 or 4; must divide XLEN.

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
start  input  1  M-type instruction valid in EX this cycle
flush  input  1  pipeline flush; aborts any operation
func3  input  3  M-extension operation select
op1  input  XLEN  forwarded rs1 (multiplicand / dividend)
op2  input  XLEN  forwarded rs2 (multiplier / divisor)
rd_in  input  5  destination register
busy  output  1  state != IDLE
stall_req  output  1  hold IF/ID/EX
done  output  1  one-cycle result-valid pulse
result  output  XLEN  registered result
rd_out  output  5  destination register for the result
wb_reg_file  output  1  equals done; write-enable toward writeback

Behaviour:
- Reset: all outputs 0; state IDLE; all internal registers 0. An asserted reset mid-operation discards the operation and leaves no done pulse.
- FSM states: IDLE, PREP, CALC, DONE.
- IDLE -> PREP: on start & ~flush. Latch func3, rd_in, op1 and op2.
- start while busy: ignored.
- start and flush in the same cycle: flush wins; the start is not accepted.
- PREP, signed operations (MULH, MULHSU-op1 only, DIV, REM):
  - Record operand signs and convert operands to magnitudes.
  - Clear the accumulator or remainder; load the counter with XLEN/BPC.
- PREP fast paths, both going straight to DONE:
  - Divisor == 0: DIV/DIVU quotient = all ones; REM/REMU = dividend.
  - DIV with op1 = most-negative and op2 = -1: quotient = op1; REM = 0.
- PREP -> CALC otherwise.
- CALC iteration step:
  - Each cycle performs BPC radix-2 steps: shift-add multiply into a 2*XLEN product, or restoring subtract-shift divide.
  - The counter decrements by 1 each cycle.
- CALC -> DONE: when the counter reaches 0.
- Result register on entering DONE:
  - Sign fix-up is applied here: product negated if the signs differ.
  - Quotient negated if the signs differ; remainder takes the dividend's sign.
  - MUL selects the low XLEN bits of the product; MULH/MULHSU/MULHU select the high XLEN bits.
- DONE -> IDLE unconditionally. done = wb_reg_file = 1 for exactly this cycle, and rd_out is valid.
- result holds its value until the next DONE. done returns to 0.
- Latency from the start-sample cycle:
  - Normal path: done in cycle XLEN/BPC + 2 (34 for defaults; 10 for BPC = 4).
  - Fast path: done in cycle 2.
- stall_req = (start & ~flush & state==IDLE) | (state==PREP) | (state==CALC). It is deasserted in DONE so the instruction advances with its result.
- flush in any non-IDLE state: next state IDLE, no done pulse, counter cleared. A start in the cycle after the flush is accepted.
- Widths: internal accumulator is 2*XLEN; remainder is XLEN+1 (sign bit for restoring compare). All arithmetic is unsigned on magnitudes.

Decomposition:
- Package m_unit_pkg:
  - func3 constants: MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
  - FSM state encoding (2 bits).
  - Helpers is_div(func3) and is_signed_op1/op2(func3).
- Sub-module m_unit_step: one combinational radix-2 multiply/divide step. It is chained BPC times via generate inside m_unit_iter; the FSM, counter and sign logic stay in the top.

Test Plan:
- MUL op1=7, op2=0xFFFFFFFD (-3), defaults -> done at cycle 34, result 0xFFFFFFEB, rd_out = rd_in, stall_req high in cycles 0-33.
- MULH op1=op2=0x80000000 -> result 0x40000000. MULHU of the same operands -> 0x40000000. MULHSU op1=0xFFFFFFFF, op2=2 -> 0xFFFFFFFF.
- DIV op1=-7, op2=2 -> 0xFFFFFFFD (-3). REM of the same operands -> 0xFFFFFFFF (-1). DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU op1=5, op2=0 -> 0xFFFFFFFF at cycle 2. REM op1=5, op2=0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, and REM -> 0, both at cycle 2.
- Flush at cycle 10 of a DIV -> busy=0 at cycle 11, no done pulse. start at cycle 11 with MUL 3*4 -> result 12 at cycle 45. Reset asserted at cycle 5 -> all outputs 0 immediately.
- BPC=4, XLEN=64: DIVU 0xFFFFFFFFFFFFFFFF / 3 -> 0x5555555555555555 at cycle 18. start pulses during busy are ignored, with no second done.
